// File: rtl/v810_bus_ctrl.sv
// V810 external bus controller: region/I-O decode, chip selects, programmed and
// device-extended wait states via READYn, 16-bit sizing requests, timeout error.
module v810_bus_ctrl #(
  parameter logic [23:0] WAIT_CFG = 24'h000000,
  parameter logic [7:0]  BUS16    = 8'h00,
  parameter logic [2:0]  IO_WAIT  = 3'd3,
  parameter logic        IO16     = 1'b1,
  parameter logic [7:0]  TIMEOUT  = 8'd64
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic        MRQn,
  input  logic        RW,
  input  logic        BCYSTn,
  input  logic        DAn,
  input  logic        EXT_READYn,
  input  logic        ERR_CLR,
  output logic        READYn,
  output logic        SZRQn,
  output logic [7:0]  CSn,
  output logic        IOCSn,
  output logic        RDn,
  output logic        WRn,
  output logic        BUSERR
);

  localparam int unsigned NUM_REGIONS = 8;
  localparam int unsigned REG_W       = 3;
  localparam int unsigned WCNT_W      = 3;
  localparam int unsigned TCNT_W      = 8;
  localparam logic [TCNT_W-1:0] TLAST = TIMEOUT - TCNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [TCNT_W-1:0]   tcnt;
  logic [REG_W-1:0]    lat_region;
  logic                lat_io;
  logic                lat_rw;
  logic                lat_bus16;
  logic                buserr;

  logic [REG_W-1:0]    dec_region;
  logic [WCNT_W-1:0]   dec_waits;
  logic                dec_bus16;
  logic                dec_io;
  logic                in_wait;
  logic                start;
  logic                timeout_hit;
  logic                ready_c;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{A[31:27], A[23:0]};

  // Address decode: memory region from A[26:24], or the I/O space when MRQn is high
  always_comb begin
    dec_region = A[26:24];
    dec_io     = MRQn;
    dec_waits  = IO_WAIT;
    dec_bus16  = IO16;
    if (!MRQn) begin
      dec_waits = '0;
      dec_bus16 = 1'b0;
      for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
        if (dec_region == REG_W'(r)) begin
          dec_waits = WAIT_CFG[REG_W*r +: WCNT_W];
          dec_bus16 = BUS16[r];
        end
      end
    end
  end

  assign in_wait     = (state == ST_WAIT);
  assign start       = CE & ~BCYSTn;
  assign timeout_hit = in_wait & (tcnt == TLAST);
  assign ready_c     = in_wait & ((~DAn & (wcnt == '0) & ~EXT_READYn) | timeout_hit);

  // State register
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state; a BCYSTn in WAIT restarts the cycle rather than completing it
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (start)                state_nxt = ST_WAIT;
        else if (CE && ready_c)   state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Cycle latches, wait counter and timeout counter
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      wcnt       <= '0;
      tcnt       <= '0;
      lat_region <= '0;
      lat_io     <= 1'b0;
      lat_rw     <= 1'b0;
      lat_bus16  <= 1'b0;
    end else if (CE) begin
      if (!BCYSTn) begin
        wcnt       <= dec_waits;
        tcnt       <= '0;
        lat_region <= dec_region;
        lat_io     <= dec_io;
        lat_rw     <= RW;
        lat_bus16  <= dec_bus16;
      end else if (in_wait) begin
        if (!DAn && (wcnt != '0)) wcnt <= wcnt - WCNT_W'(1);
        if (tcnt != TLAST)        tcnt <= tcnt + TCNT_W'(1);
      end
    end
  end

  // Sticky timeout flag; a set wins over a simultaneous clear
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      buserr <= 1'b0;
    end else if (CE) begin
      if (timeout_hit && BCYSTn) buserr <= 1'b1;
      else if (ERR_CLR)          buserr <= 1'b0;
    end
  end

  // Outputs: decoded selects during T1, latched selects during WAIT
  always_comb begin
    READYn = 1'b1;
    SZRQn  = 1'b1;
    CSn    = '1;
    IOCSn  = 1'b1;
    RDn    = 1'b1;
    WRn    = 1'b1;
    if (RESn && !BCYSTn) begin
      SZRQn = ~dec_bus16;
      if (dec_io) IOCSn = 1'b0;
      else        CSn[dec_region] = 1'b0;
    end else if (in_wait) begin
      SZRQn = ~lat_bus16;
      if (lat_io) IOCSn = 1'b0;
      else        CSn[lat_region] = 1'b0;
    end
    READYn = ~ready_c;
    RDn    = ~(in_wait & ~DAn & lat_rw);
    WRn    = ~(in_wait & ~DAn & ~lat_rw);
  end

  assign BUSERR = buserr;

endmodule

// File: tb/tb_v810_bus_ctrl.sv
// Bench for v810_bus_ctrl: directed and randomized bus cycles checked against a
// transaction-level model of waits, selects, strobes and the timeout flag.
module tb_v810_bus_ctrl;

  localparam logic [23:0] WCFG = 24'h9C5650;
  localparam logic [7:0]  B16  = 8'h25;
  localparam int          TMO  = 64;

  int waits_tbl [8] = '{0, 2, 1, 3, 5, 0, 7, 4};
  bit bus16_tbl [8] = '{1, 0, 1, 0, 0, 1, 0, 0};

  logic        CLK = 1'b0;
  logic        RESn = 1'b0;
  logic        CE = 1'b1;
  logic [31:0] A = '0;
  logic        MRQn = 1'b0;
  logic        RW = 1'b1;
  logic        BCYSTn = 1'b1;
  logic        DAn = 1'b1;
  logic        EXT_READYn = 1'b1;
  logic        ERR_CLR = 1'b0;
  logic        READYn, SZRQn, IOCSn, RDn, WRn, BUSERR;
  logic [7:0]  CSn;

  int   checks = 0;
  int   errors = 0;
  logic exp_buserr = 1'b0;

  v810_bus_ctrl #(
    .WAIT_CFG(WCFG), .BUS16(B16), .IO_WAIT(3'd3), .IO16(1'b1), .TIMEOUT(8'(TMO))
  ) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .A(A), .MRQn(MRQn), .RW(RW),
    .BCYSTn(BCYSTn), .DAn(DAn), .EXT_READYn(EXT_READYn), .ERR_CLR(ERR_CLR),
    .READYn(READYn), .SZRQn(SZRQn), .CSn(CSn), .IOCSn(IOCSn),
    .RDn(RDn), .WRn(WRn), .BUSERR(BUSERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string ph, input logic rdy_n, input logic sz_n,
                          input logic [7:0] cs, input logic iocs,
                          input logic rd_n, input logic wr_n);
    chk({ph, "_readyn"}, 32'(READYn), 32'(rdy_n));
    chk({ph, "_szrqn"},  32'(SZRQn),  32'(sz_n));
    chk({ph, "_csn"},    32'(CSn),    32'(cs));
    chk({ph, "_iocsn"},  32'(IOCSn),  32'(iocs));
    chk({ph, "_rdn"},    32'(RDn),    32'(rd_n));
    chk({ph, "_wrn"},    32'(WRn),    32'(wr_n));
    chk({ph, "_buserr"}, 32'(BUSERR), 32'(exp_buserr));
  endtask

  // Flag model for the coming clock edge
  task automatic flag_update(input bit set);
    if (CE) begin
      if (set)          exp_buserr = 1'b1;
      else if (ERR_CLR) exp_buserr = 1'b0;
    end
  endtask

  task automatic idle(input int k, input logic clr, input bit rand_ce);
    for (int i = 0; i < k; i++) begin
      BCYSTn = 1'b1; DAn = 1'b1; ERR_CLR = clr;
      CE = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
      A = $urandom; MRQn = 1'($urandom); RW = 1'($urandom);
      EXT_READYn = 1'($urandom);
      @(negedge CLK);
      chk_outs("idle", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
      flag_update(1'b0);
      @(posedge CLK); #1;
    end
    ERR_CLR = 1'b0; CE = 1'b1;
  endtask

  // One bus cycle: T1, then T2s until completion (or max_t2 data cycles if >= 0)
  task automatic bus_cycle(input logic [31:0] addr, input logic mrqn, input logic rw,
                           input int ext_delay, input int max_t2, input bit stall);
    int n, t2, tc;
    bit io, b16, rdy, tmo, done;
    logic [7:0] cs_e;
    logic iocs_e, sz_e, rd_e, wr_e;
    io   = mrqn;
    n    = io ? 3 : waits_tbl[addr[26:24]];
    b16  = io ? 1'b1 : bus16_tbl[addr[26:24]];
    cs_e = 8'hFF;
    if (!io) cs_e[addr[26:24]] = 1'b0;
    iocs_e = ~io;
    sz_e   = ~b16;
    A = addr; MRQn = mrqn; RW = rw; BCYSTn = 1'b0; DAn = 1'b1; CE = 1'b1;
    EXT_READYn = 1'b1;
    @(negedge CLK);
    chk_outs("t1", 1'b1, sz_e, cs_e, iocs_e, 1'b1, 1'b1);
    flag_update(1'b0);
    @(posedge CLK); #1;
    BCYSTn = 1'b1;
    t2 = 0; tc = 0; done = 1'b0;
    while (!done) begin
      if (tc > 300) begin
        chk("cycle_bound", 32'(tc), 32'(TMO));
        break;
      end
      if (max_t2 >= 0 && t2 >= max_t2) break;
      CE   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      DAn  = stall ? ($urandom_range(0, 4) == 0) : 1'b0;
      A    = $urandom; MRQn = 1'($urandom); RW = 1'($urandom);
      EXT_READYn = (t2 < ext_delay);
      tmo  = (tc == TMO - 1);
      rdy  = (!DAn && t2 >= n && !EXT_READYn) || tmo;
      rd_e = (!DAn && rw)  ? 1'b0 : 1'b1;
      wr_e = (!DAn && !rw) ? 1'b0 : 1'b1;
      @(negedge CLK);
      chk_outs("t2", ~rdy, sz_e, cs_e, iocs_e, rd_e, wr_e);
      flag_update(tmo);
      @(posedge CLK); #1;
      if (CE) begin
        if (rdy)  done = 1'b1;
        if (!DAn) t2++;
        tc++;
      end
    end
    BCYSTn = 1'b1; DAn = 1'b1; CE = 1'b1;
  endtask

  initial begin
    // Reset state, with a T1 on the bus that must not leak through
    RESn = 1'b0; BCYSTn = 1'b0;
    #12;
    chk_outs("reset", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    BCYSTn = 1'b1;
    @(negedge CLK); RESn = 1'b1;
    @(posedge CLK); #1;

    // Region 1, two waits, read
    bus_cycle(32'h0100_0000, 1'b0, 1'b1, 0, -1, 1'b0);
    idle(1, 1'b0, 1'b0);

    // Region 0, 16-bit, zero waits: first halfword then back-to-back T1S
    bus_cycle(32'h0000_0000, 1'b0, 1'b1, 0, -1, 1'b0);
    bus_cycle(32'h0000_0002, 1'b0, 1'b1, 0, -1, 1'b0);
    idle(1, 1'b0, 1'b0);

    // I/O write, three waits
    bus_cycle(32'h1234_5678, 1'b1, 1'b0, 0, -1, 1'b0);
    idle(1, 1'b0, 1'b0);

    // Region 2, one wait, device holds off for 10 data cycles
    bus_cycle(32'h0200_0000, 1'b0, 1'b1, 10, -1, 1'b0);
    idle(2, 1'b0, 1'b0);

    // Timeout forces completion and sets the flag; a clear pulse removes it
    bus_cycle(32'h0300_0000, 1'b0, 1'b1, 1000, -1, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);

    // Clear held through a timeout: set wins
    ERR_CLR = 1'b1;
    bus_cycle(32'h0600_0000, 1'b0, 1'b0, 1000, -1, 1'b1);
    ERR_CLR = 1'b0;
    idle(2, 1'b0, 1'b0);

    // Reset in the second T2 of a three-wait cycle
    bus_cycle(32'h0300_0000, 1'b0, 1'b1, 0, 1, 1'b0);
    DAn = 1'b0; BCYSTn = 1'b1; CE = 1'b1; EXT_READYn = 1'b0;
    #1;
    chk("pre_rst_readyn", 32'(READYn), 32'd1);
    chk("pre_rst_rdn", 32'(RDn), 32'd0);
    RESn = 1'b0; BCYSTn = 1'b0;
    exp_buserr = 1'b0;
    #1;
    chk_outs("mid_rst", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); BCYSTn = 1'b1; DAn = 1'b1; RESn = 1'b1;
    @(posedge CLK); #1;
    bus_cycle(32'h0300_0000, 1'b0, 1'b1, 0, -1, 1'b0);
    idle(1, 1'b0, 1'b0);

    // BCYSTn during WAIT restarts from the new decode
    bus_cycle(32'h0700_0000, 1'b0, 1'b1, 0, 1, 1'b0);
    bus_cycle(32'h0100_0010, 1'b0, 1'b0, 0, -1, 1'b0);
    idle(1, 1'b0, 1'b0);

    // Randomized traffic with clock-enable gaps and data-access stalls
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr;
      logic        mrqn;
      addr = $urandom;
      addr[26:24] = 3'($urandom_range(0, 7));
      mrqn = ($urandom_range(0, 3) == 0);
      bus_cycle(addr, mrqn, 1'($urandom), $urandom_range(0, 6), -1, 1'b1);
      idle($urandom_range(0, 2), 1'($urandom_range(0, 5) == 0), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/v810_bus_ctrl.md
Name: v810_bus_ctrl

Overview:
- External bus controller on the board side of the V810 external bus interface.
- Decodes the address of each bus cycle into one of 8 memory regions or the I/O space, and drives a chip select.
- Inserts per-region programmed wait states and optional device-extended waits by sequencing READYn.
- Requests 16-bit dynamic bus sizing via SZRQn, and forces completion with a sticky error on bus timeout.

Parameters:
- WAIT_CFG, 24'h000000: wait states per memory region, 3 bits each; region r at [3r+2:3r].
- BUS16, 8'h00: bit r set means region r is a 16-bit device.
- IO_WAIT, 3'd3: wait states for I/O cycles (MRQn high).
- IO16, 1'b1: I/O space is 16-bit.
- TIMEOUT, 8'd64: CE cycles in WAIT before completion is forced; legal range 2..255.

Ports:
- CLK  in  1  system clock.
- RESn  in  1  reset; asynchronous, active-low.
- CE  in  1  global clock enable; all state advances only when CE is high.
- A  in  32  CPU bus address; the region index is A[26:24].
- MRQn  in  1  memory request; high means an I/O cycle.
- RW  in  1  1 = read, 0 = write.
- BCYSTn  in  1  bus cycle start (T1/T1S).
- DAn  in  1  data access (T2/T2S).
- EXT_READYn  in  1  device wait extension; low = device ready.
- ERR_CLR  in  1  clears BUSERR.
- READYn  out  1  cycle completion to the CPU.
- SZRQn  out  1  16-bit sizing request to the CPU.
- CSn  out  8  one-hot active-low memory region selects.
- IOCSn  out  1  I/O space select.
- RDn  out  1  read strobe.
- WRn  out  1  write strobe.
- BUSERR  out  1  sticky timeout flag.

Behaviour:
- Reset: RESn low asynchronously forces the following, in any state including mid-cycle:
  - FSM to IDLE; wait counter and timeout counter to 0; latched region to 0.
  - BUSERR=0, READYn=1, SZRQn=1, CSn=8'hFF, IOCSn=1, RDn=1, WRn=1.
- Decode, combinational from A and MRQn:
  - MRQn=0: region = A[26:24]; waits = WAIT_CFG[region]; bus16 = BUS16[region].
  - MRQn=1: I/O cycle; waits = IO_WAIT; bus16 = IO16.
- FSM states are IDLE and WAIT.
  - IDLE, on a CE cycle with BCYSTn=0: latch region/io/RW, load wcnt=waits, clear tcnt, go to WAIT.
  - WAIT, on each CE cycle with DAn=0: if wcnt!=0 then wcnt-1; tcnt+1 every CE cycle.
  - WAIT, on a CE cycle with READYn=0: go to IDLE.
- READYn (combinational from registered state) is 0 iff:
  - state==WAIT, DAn=0, wcnt==0 and EXT_READYn=0; or
  - state==WAIT and tcnt==TIMEOUT-1 (forced completion).
- Latency: with N programmed waits and EXT_READYn held low, READYn is low in the (N+1)th T2 cycle.
- Timeout: a forced completion sets BUSERR=1 on that CE edge.
  - BUSERR holds until an ERR_CLR=1 CE cycle clears it.
  - A simultaneous set and clear leaves BUSERR=1.
- SZRQn:
  - T1 cycle (BCYSTn=0): ~bus16 of the current decode.
  - WAIT: ~bus16 of the latched decode.
  - Otherwise: 1.
- Second halfword (T1S): BCYSTn=0 arrives in IDLE after completion and is handled as a fresh cycle (reload, same region).
- BCYSTn=0 while in WAIT is a protocol error:
  - Restart: relatch and reload wcnt from the current decode, clear tcnt.
  - BUSERR is unaffected.
- Selects and strobes:
  - CSn[region]=0 during the T1 cycle (decoded) and throughout WAIT (latched); never for I/O cycles.
  - IOCSn=0 under the same timing for I/O cycles.
  - RDn = ~(state==WAIT & DAn=0 & RW=1).
  - WRn = ~(state==WAIT & DAn=0 & RW=0).
- CE low: outputs remain a function of the held state; no counter or flag changes.
- Width rules:
  - wcnt is 3 bits and does not wrap below 0.
  - tcnt is 8 bits and saturates at TIMEOUT-1.

Test Plan:
- WAIT_CFG region1=2, A=32'h0100_0000, MRQn=0, read, EXT_READYn=0 -> CSn=8'hFD from T1; READYn low only in the 3rd T2 cycle; RDn low for all 3 T2 cycles; then IDLE with CSn=8'hFF.
- Region0 waits=0, BUS16[0]=1, 32-bit read -> SZRQn=0 in T1; READYn low in the first T2; T1S handled as a second 0-wait cycle, READYn low again on the first T2S.
- I/O write, MRQn=1 -> IOCSn=0, CSn=8'hFF, WRn low; READYn low in the 4th T2 (IO_WAIT=3).
- Region waits=1, EXT_READYn held high 10 cycles then low -> READYn low in the first T2 after EXT_READYn falls; BUSERR stays 0.
- EXT_READYn held high, TIMEOUT=64 -> READYn forced low at tcnt=63; BUSERR=1; ERR_CLR pulse -> BUSERR=0.
- RESn low in the 2nd T2 of a 3-wait cycle -> immediately READYn=1, CSn=8'hFF, RDn=1; after release, the next BCYSTn starts a clean cycle.
